// File: rtl/mult_seq_ctrl.sv
// Operand capture and iterative shift-add multiply sequencer for the 8x8 multiply lab.
// Keys are synchronised and edge-detected; operands and product live in clocked registers.
module mult_seq_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw_data,
  input  logic               sel_b,
  input  logic               load_n,
  input  logic               start_n,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   led_op,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);
  // state | meaning
  // IDLE  | waiting for load/start presses
  // RUN   | WIDTH shift-add iterations
  // DONE  | product copied to result, done high
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] load_sync, start_sync;
  logic                   load_prev, start_prev;
  logic                   load_press, start_press;
  logic [2*WIDTH-1:0]     acc, mcand;
  logic [WIDTH-1:0]       mplier;
  logic [CW-1:0]          cnt;

  // Sync chains reset to the released level so reset never fakes a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_sync  <= '1;
      start_sync <= '1;
      load_prev  <= 1'b1;
      start_prev <= 1'b1;
    end else begin
      load_sync  <= {load_sync[SYNC_STAGES-2:0], load_n};
      start_sync <= {start_sync[SYNC_STAGES-2:0], start_n};
      load_prev  <= load_sync[SYNC_STAGES-1];
      start_prev <= start_sync[SYNC_STAGES-1];
    end
  end

  assign load_press  = load_prev  & ~load_sync[SYNC_STAGES-1];
  assign start_press = start_prev & ~start_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A load wins over a coincident start.
          if (load_press) begin
            if (sel_b) op_b <= sw_data;
            else       op_a <= sw_data;
          end else if (start_press) begin
            state  <= RUN;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          result <= acc;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign led_op = sel_b ? op_b : op_a;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: key capture, multiply timing, discarded presses, reset abort.
module tb_mult_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw_data;
  logic        sel_b;
  logic        load_n;
  logic        start_n;
  logic [7:0]  op_a, op_b, led_op;
  logic [15:0] result;
  logic        busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  mult_seq_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .sel_b(sel_b),
    .load_n(load_n), .start_n(start_n), .op_a(op_a), .op_b(op_b),
    .led_op(led_op), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic sb, input logic [7:0] d);
    sel_b = sb; sw_data = d; load_n = 1'b0;
    step(3);
    load_n = 1'b1;
    step(3);
  endtask

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string name);
    logic [15:0] prev;
    int busy_cnt, done_cnt;
    do_load(1'b0, a);
    do_load(1'b1, b);
    prev = result;
    start_n = 1'b0;
    step(3);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s start_accept busy=%b required 1", name, busy);
    end
    busy_cnt = 1; done_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 1) start_n = 1'b1;
      step(1);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (i == 8) begin
        tests_run++;
        if (done !== 1'b1 || result !== prev) begin
          tests_failed++;
          $display("FAIL %s edge8 done=%b result=%h required done=1 result=%h", name, done, result, prev);
        end
      end
    end
    tests_run++;
    if (result !== exp) begin
      tests_failed++;
      $display("FAIL %s result=%h required %h", name, result, exp);
    end
    tests_run++;
    if (busy_cnt != 9 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL %s busy_cycles=%0d done_pulses=%0d required 9 and 1", name, busy_cnt, done_cnt);
    end
    tests_run++;
    if (op_a !== a || op_b !== b) begin
      tests_failed++;
      $display("FAIL %s operands op_a=%h op_b=%h required %h %h", name, op_a, op_b, a, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_data = 8'h00; sel_b = 1'b0; load_n = 1'b1; start_n = 1'b1;
    step(2);
    tests_run++;
    if (op_a !== 8'h00 || op_b !== 8'h00 || result !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset op_a=%h op_b=%h result=%h busy=%b done=%b required all 0",
               op_a, op_b, result, busy, done);
    end
    rst = 1'b0;
    step(6);
    tests_run++;
    if (busy !== 1'b0 || op_a !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_release busy=%b op_a=%h required 0 00", busy, op_a);
    end
  endtask

  task automatic test_basic();
    run_mult(8'h0C, 8'h0A, 16'h0078, "basic_0c_0a");
    sel_b = 1'b0; #1;
    tests_run++;
    if (led_op !== 8'h0C) begin
      tests_failed++;
      $display("FAIL led_op_a led_op=%h required 0c", led_op);
    end
    sel_b = 1'b1; #1;
    tests_run++;
    if (led_op !== 8'h0A) begin
      tests_failed++;
      $display("FAIL led_op_b led_op=%h required 0a", led_op);
    end
  endtask

  task automatic test_max();
    run_mult(8'hFF, 8'hFF, 16'hFE01, "max_ff_ff");
  endtask

  task automatic test_zero();
    run_mult(8'h00, 8'hB7, 16'h0000, "zero_a");
    run_mult(8'h5A, 8'h01, 16'h005A, "one_b");
  endtask

  task automatic test_busy_presses();
    int done_cnt;
    do_load(1'b0, 8'h06);
    do_load(1'b1, 8'h07);
    start_n = 1'b0;
    step(3);
    done_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 1) begin start_n = 1'b1; load_n = 1'b0; sel_b = 1'b0; sw_data = 8'h33; end
      if (i == 3) start_n = 1'b0;
      if (i == 4) load_n = 1'b1;
      if (i == 6) start_n = 1'b1;
      step(1);
      if (done === 1'b1) done_cnt++;
    end
    step(8);
    if (done === 1'b1) done_cnt++;
    tests_run++;
    if (op_a !== 8'h06 || op_b !== 8'h07) begin
      tests_failed++;
      $display("FAIL busy_presses operands op_a=%h op_b=%h required 06 07", op_a, op_b);
    end
    tests_run++;
    if (result !== 16'h002A || done_cnt != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_presses result=%h done_pulses=%0d busy=%b required 002a 1 0",
               result, done_cnt, busy);
    end
  endtask

  task automatic test_hold();
    sel_b = 1'b0; sw_data = 8'h11; load_n = 1'b0;
    step(3);
    tests_run++;
    if (op_a !== 8'h11) begin
      tests_failed++;
      $display("FAIL hold_capture op_a=%h required 11", op_a);
    end
    sw_data = 8'h22;
    step(47);
    tests_run++;
    if (op_a !== 8'h11) begin
      tests_failed++;
      $display("FAIL hold_single op_a=%h required 11", op_a);
    end
    load_n = 1'b1;
    step(3);
    sel_b = 1'b1; sw_data = 8'h44; load_n = 1'b0; start_n = 1'b0;
    step(3);
    load_n = 1'b1; start_n = 1'b1;
    step(1);
    tests_run++;
    if (op_b !== 8'h44 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL simultaneous op_b=%h busy=%b required 44 0", op_b, busy);
    end
    step(5);
    tests_run++;
    if (busy !== 1'b0 || op_a !== 8'h11 || led_op !== 8'h44) begin
      tests_failed++;
      $display("FAIL simultaneous_after busy=%b op_a=%h led_op=%h required 0 11 44", busy, op_a, led_op);
    end
    sel_b = 1'b0;
    step(2);
    tests_run++;
    if (led_op !== 8'h11 || op_b !== 8'h44 || result !== 16'h002A) begin
      tests_failed++;
      $display("FAIL sel_toggle led_op=%h op_b=%h result=%h required 11 44 002a", led_op, op_b, result);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    run_mult(8'h03, 8'h04, 16'h000C, "pre_abort_03_04");
    do_load(1'b0, 8'hFF);
    do_load(1'b1, 8'hFF);
    start_n = 1'b0;
    step(3);
    start_n = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    tests_run++;
    if (op_a !== 8'h00 || op_b !== 8'h00 || result !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort op_a=%h op_b=%h result=%h busy=%b done=%b required all 0",
               op_a, op_b, result, busy, done);
    end
    step(1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || result !== 16'h0) begin
      tests_failed++;
      $display("FAIL abort_after bad_cycles=%0d result=%h required 0 0000", bad, result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_busy_presses();
    test_hold();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
